// File: rtl/ssdec_pkg.sv
// Shared types and glyph constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package ssdec_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam seg_t GLYPH_TAB [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/ssdec_scan_if.sv
// Digit-data and display-drive bundle for ssdec_scan; the slave side is the
// scan driver, the master side is whoever loads digits and watches the panel.
interface ssdec_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    load;
    ssdec_pkg::seg_t         seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits, digit_en, blink_mask, load,
        input  seg, an, frame_done
    );

    modport slave (
        input  digits, digit_en, blink_mask, load,
        output seg, an, frame_done
    );
endinterface

// File: rtl/ssdec_glyph.sv
// Hex nibble to seven-segment decoder; a disabled decoder emits a blank glyph.
module ssdec_glyph
    import ssdec_pkg::*;
(
    input  logic [3:0] val,
    input  logic       en,
    output seg_t       seg
);
    assign seg = en ? GLYPH_TAB[val] : SEG_BLANK;
endmodule

// File: rtl/ssdec_scan.sv
// Time-multiplexed seven-segment scan driver with frame-buffered digits and
// slot-start blanking. Per-digit blink is built only with SSDEC_SCAN_BLINK_EN.
module ssdec_scan
    import ssdec_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input logic         clk,
    input logic         nrst,
    ssdec_scan_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          wrap;

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign wrap     = slot_end && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0][3:0] pend_dig, shad_dig;
    logic [NUM_DIGITS-1:0]      pend_en, shad_en;
    logic                       pend_flag;
    logic                       take;

    // A load on the wrap edge itself goes straight to the shadow.
    assign take = wrap && (pend_flag || bus.load);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_dig  <= '0;
            pend_en   <= '0;
            pend_flag <= 1'b0;
            shad_dig  <= '0;
            shad_en   <= '0;
        end else begin
            if (bus.load) begin
                pend_dig <= bus.digits;
                pend_en  <= bus.digit_en;
            end
            if (bus.load)  pend_flag <= !wrap;
            else if (wrap) pend_flag <= 1'b0;
            if (take) begin
                shad_dig <= bus.load ? bus.digits   : pend_dig;
                shad_en  <= bus.load ? bus.digit_en : pend_en;
            end
        end
    end

    logic blink_hide;

`ifdef SSDEC_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0] pend_blink, shad_blink;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_phase;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_blink  <= '0;
            shad_blink  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (bus.load) pend_blink <= bus.blink_mask;
            if (take)     shad_blink <= bus.load ? bus.blink_mask : pend_blink;
            if (wrap) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign blink_hide = blink_phase & shad_blink[idx];
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink_mask;
    assign blink_hide   = 1'b0;
`endif

    logic                  lit;
    seg_t                  seg_d;
    logic [NUM_DIGITS-1:0] sel_oh;

    assign lit    = shad_en[idx] && (cnt >= CW'(BLANK_CYCLES)) && !blink_hide;
    assign sel_oh = NUM_DIGITS'(1) << idx;

    ssdec_glyph u_glyph (
        .val (shad_dig[idx]),
        .en  (lit),
        .seg (seg_d)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.seg        <= SEG_BLANK;
            bus.an         <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg        <= seg_d;
            bus.an         <= lit ? sel_oh : '0;
            bus.frame_done <= (cnt == '0) && (idx == '0);
        end
    end
endmodule
